// File: rtl/backend_mux_pkg.sv
// Shared constants, state encodings and arithmetic helpers for the backend_mux
// game-logic core and its CPU opponent.
package backend_mux_pkg;

  localparam logic [7:0] DEF_START_HEALTH  = 8'd100;
  localparam logic [7:0] DEF_P1_DAMAGE     = 8'd10;
  localparam logic [7:0] DEF_CPU_DAMAGE    = 8'd8;
  localparam int         DEF_CPU_PERIOD    = 16;
  localparam int         DEF_ATTACK_WINDOW = 4;
  localparam logic [7:0] DEF_LFSR_SEED     = 8'hA5;

  typedef enum logic {
    PLAY,
    GAME_OVER
  } top_state_t;

  typedef enum logic [1:0] {
    CPU_IDLE,
    CPU_ATTACK,
    CPU_BLOCK
  } cpu_state_t;

  // Health never wraps: any damage larger than what is left lands on zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/backend_mux_if.sv
// Keyboard command in, health and CPU-attack status out.
interface backend_mux_if;
  logic [3:0] keyboard_input;
  logic [7:0] p1_health_out;
  logic [7:0] cpu_health_out;
  logic       cpu_isAttacking;

  modport master (
    output keyboard_input,
    input  p1_health_out,
    input  cpu_health_out,
    input  cpu_isAttacking
  );

  modport slave (
    input  keyboard_input,
    output p1_health_out,
    output cpu_health_out,
    output cpu_isAttacking
  );
endinterface

// File: rtl/backend_mux_cpu_ai.sv
// CPU opponent: decision counter, LFSR and attack/block window FSM.
// strike_pulse is combinational so the hit lands on the edge that ends the window.
module backend_mux_cpu_ai
  import backend_mux_pkg::*;
#(
  parameter int         CPU_PERIOD    = DEF_CPU_PERIOD,
  parameter int         ATTACK_WINDOW = DEF_ATTACK_WINDOW,
  parameter logic [7:0] LFSR_SEED     = DEF_LFSR_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic run_next,
  output logic cpu_attacking,
  output logic cpu_blocking,
  output logic strike_pulse
);

  localparam int CW = $clog2(CPU_PERIOD + 1);
  localparam int WW = $clog2(ATTACK_WINDOW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPU_PERIOD - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(ATTACK_WINDOW - 1);

  cpu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] win_q, win_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          attacking_q, attacking_d;
  logic          blocking_q, blocking_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    lfsr_d       = lfsr_q;
    strike_pulse = 1'b0;
    if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      case (state_q)
        CPU_IDLE: begin
          if (cnt_q == CNT_LAST) begin
            lfsr_d  = lfsr_step(lfsr_q);
            state_d = lfsr_q[0] ? CPU_ATTACK : CPU_BLOCK;
            win_d   = '0;
          end
        end
        CPU_ATTACK, CPU_BLOCK: begin
          if (win_q == WIN_LAST) begin
            state_d      = CPU_IDLE;
            strike_pulse = (state_q == CPU_ATTACK);
          end else begin
            win_d = win_q + WW'(1);
          end
        end
        default: state_d = CPU_IDLE;
      endcase
    end
    // Flags look one edge ahead so they drop the moment the round ends.
    attacking_d = run_next && (state_d == CPU_ATTACK);
    blocking_d  = run_next && (state_d == CPU_BLOCK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CPU_IDLE;
      cnt_q       <= '0;
      win_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      attacking_q <= 1'b0;
      blocking_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      lfsr_q      <= lfsr_d;
      attacking_q <= attacking_d;
      blocking_q  <= blocking_d;
    end
  end

  assign cpu_attacking = attacking_q;
  assign cpu_blocking  = blocking_q;

endmodule

// File: rtl/backend_mux.sv
// BruteForce game-logic core: player attack/block against the CPU opponent,
// both health registers and the round (PLAY / GAME_OVER) state.
module backend_mux
  import backend_mux_pkg::*;
#(
  parameter logic [7:0] START_HEALTH  = DEF_START_HEALTH,
  parameter logic [7:0] P1_DAMAGE     = DEF_P1_DAMAGE,
  parameter logic [7:0] CPU_DAMAGE    = DEF_CPU_DAMAGE,
  parameter int         CPU_PERIOD    = DEF_CPU_PERIOD,
  parameter int         ATTACK_WINDOW = DEF_ATTACK_WINDOW,
  parameter logic [7:0] LFSR_SEED     = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  backend_mux_if.slave bus
);

  top_state_t top_q, top_d;
  logic [7:0] p1_q, p1_d;
  logic [7:0] cpu_q, cpu_d;
  logic       kb0_prev_q, kb0_prev_d;
  logic       run, run_next;
  logic       p1_hit;
  logic       cpu_attacking, cpu_blocking, strike_pulse;
  logic [1:0] unused_kb;

  assign unused_kb = bus.keyboard_input[3:2];

  backend_mux_cpu_ai #(
    .CPU_PERIOD    (CPU_PERIOD),
    .ATTACK_WINDOW (ATTACK_WINDOW),
    .LFSR_SEED     (LFSR_SEED)
  ) u_cpu_ai (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .run_next      (run_next),
    .cpu_attacking (cpu_attacking),
    .cpu_blocking  (cpu_blocking),
    .strike_pulse  (strike_pulse)
  );

  always_comb begin
    run        = (top_q == PLAY);
    top_d      = (run && ((p1_q == 8'd0) || (cpu_q == 8'd0))) ? GAME_OVER : top_q;
    run_next   = (top_d == PLAY);
    kb0_prev_d = bus.keyboard_input[0];
    p1_hit     = bus.keyboard_input[0] && !kb0_prev_q;

    cpu_d = cpu_q;
    if (run && p1_hit && !cpu_blocking) begin
      cpu_d = sat_sub(cpu_q, P1_DAMAGE);
    end

    p1_d = p1_q;
    if (run && strike_pulse && !bus.keyboard_input[1]) begin
      p1_d = sat_sub(p1_q, CPU_DAMAGE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q      <= PLAY;
      p1_q       <= START_HEALTH;
      cpu_q      <= START_HEALTH;
      kb0_prev_q <= 1'b0;
    end else begin
      top_q      <= top_d;
      p1_q       <= p1_d;
      cpu_q      <= cpu_d;
      kb0_prev_q <= kb0_prev_d;
    end
  end

  assign bus.p1_health_out   = p1_q;
  assign bus.cpu_health_out  = cpu_q;
  assign bus.cpu_isAttacking = cpu_attacking;

endmodule

// File: tb/tb_backend_mux.sv
// Directed bench: dut_a uses default parameters, dut_b uses P1_DAMAGE=30 for
// the saturation case. Edges are numbered from reset release (edge 1 first).
module tb_backend_mux;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;

  backend_mux_if bus_a();
  backend_mux_if bus_b();

  backend_mux dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  backend_mux #(.P1_DAMAGE(8'd30)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    end else begin
      $display("ok   %s @edge %0d: %0d", tag, edge_n, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic goto_edge(input int e);
    while (edge_n < e) tick();
  endtask

  initial begin
    int exp_b[4];
    exp_b = '{70, 40, 10, 0};

    reset = 1'b0;
    bus_a.keyboard_input = 4'b0000;
    bus_b.keyboard_input = 4'b0000;
    repeat (3) tick();
    check_eq("rst_p1_a",  32'(bus_a.p1_health_out),   32'd100);
    check_eq("rst_cpu_a", 32'(bus_a.cpu_health_out),  32'd100);
    check_eq("rst_att_a", 32'(bus_a.cpu_isAttacking), 32'd0);
    check_eq("rst_cpu_b", 32'(bus_b.cpu_health_out),  32'd100);

    // Single press then hold: only the rising edge counts.
    bus_a.keyboard_input = 4'b0001;
    reset  = 1'b1;
    edge_n = 0;
    tick();
    check_eq("hit1_cpu", 32'(bus_a.cpu_health_out), 32'd90);
    goto_edge(5);
    check_eq("hold_cpu", 32'(bus_a.cpu_health_out), 32'd90);
    bus_a.keyboard_input = 4'b0000;

    // dut_b: 100 -> 70 -> 40 -> 10 -> 0 (saturates, no wrap).
    goto_edge(7);
    for (int i = 0; i < 4; i++) begin
      bus_b.keyboard_input = 4'b0001;
      tick();
      check_eq("sat_cpu_b", 32'(bus_b.cpu_health_out), 32'(exp_b[i]));
      bus_b.keyboard_input = 4'b0000;
      tick();
    end

    // First decision (seed A5, bit0=1) at edge 16: attack for 4 cycles.
    check_eq("pre_att", 32'(bus_a.cpu_isAttacking), 32'd0);
    goto_edge(16);
    check_eq("att_b_frozen", 32'(bus_b.cpu_isAttacking), 32'd0);
    check_eq("cpu_b_frozen", 32'(bus_b.cpu_health_out),  32'd0);
    for (int e = 16; e <= 19; e++) begin
      goto_edge(e);
      check_eq("att_win", 32'(bus_a.cpu_isAttacking), 32'd1);
      check_eq("p1_win",  32'(bus_a.p1_health_out),   32'd100);
    end
    goto_edge(20);
    check_eq("att_end",   32'(bus_a.cpu_isAttacking), 32'd0);
    check_eq("strike_p1", 32'(bus_a.p1_health_out),   32'd92);

    // Second decision (lfsr 4A, bit0=0) at edge 32: block on edges 33..36.
    goto_edge(33);
    check_eq("blk_no_att", 32'(bus_a.cpu_isAttacking), 32'd0);
    bus_a.keyboard_input = 4'b0001;
    tick();
    check_eq("blk_cpu", 32'(bus_a.cpu_health_out), 32'd90);
    bus_a.keyboard_input = 4'b0000;
    goto_edge(37);
    bus_a.keyboard_input = 4'b0001;
    tick();
    check_eq("post_blk_cpu", 32'(bus_a.cpu_health_out), 32'd80);
    bus_a.keyboard_input = 4'b0000;

    // Third decision (lfsr 95, bit0=1) at edge 48; player blocks the strike.
    goto_edge(47);
    bus_a.keyboard_input = 4'b0010;
    goto_edge(49);
    check_eq("att2_win", 32'(bus_a.cpu_isAttacking), 32'd1);
    goto_edge(52);
    check_eq("blocked_p1", 32'(bus_a.p1_health_out),   32'd92);
    check_eq("att2_end",   32'(bus_a.cpu_isAttacking), 32'd0);

    // Toggle attacks down to zero, skipping the CPU block window 65..68.
    for (int i = 0; i < 8; i++) begin
      if (i == 6) goto_edge(68);
      bus_a.keyboard_input = 4'b0001;
      tick();
      check_eq("drain_cpu", 32'(bus_a.cpu_health_out), 32'(70 - 10 * i));
      bus_a.keyboard_input = 4'b0000;
      tick();
    end

    // GAME_OVER: an unfrozen CPU would attack at edge 112 and strike at 116.
    while (edge_n < 120) begin
      bus_a.keyboard_input = (edge_n % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      check_eq("over_att", 32'(bus_a.cpu_isAttacking), 32'd0);
    end
    bus_a.keyboard_input = 4'b0000;
    check_eq("over_cpu", 32'(bus_a.cpu_health_out), 32'd0);
    check_eq("over_p1",  32'(bus_a.p1_health_out),  32'd92);

    // Async reset in the middle of an attack window.
    reset = 1'b0;
    repeat (2) tick();
    bus_a.keyboard_input = 4'b0001;
    reset  = 1'b1;
    edge_n = 0;
    tick();
    check_eq("r2_hit_cpu", 32'(bus_a.cpu_health_out), 32'd90);
    bus_a.keyboard_input = 4'b0000;
    goto_edge(18);
    check_eq("r2_att", 32'(bus_a.cpu_isAttacking), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_att", 32'(bus_a.cpu_isAttacking), 32'd0);
    check_eq("arst_cpu", 32'(bus_a.cpu_health_out),  32'd100);
    check_eq("arst_p1",  32'(bus_a.p1_health_out),   32'd100);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
